// File: rtl/pe_demux.sv
// PE-side demultiplexer: two per-VC flit FIFOs feeding one PE port with packet-level VC locking.
// Optional macro PE_DEMUX_OVF_CHK_EN enables the sticky overflow flag on err.
//
// state | meaning
// IDLE  | no packet open; pick a VC whose front flit is a head
// LOCK0 | packet in progress on VC0, only VC0 presented
// LOCK1 | packet in progress on VC1, only VC1 presented
module pe_demux #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  input  logic             ivch,
  output logic [1:0]       ocredit,
  output logic [WIDTH-1:0] odata,
  output logic             ovalid,
  output logic             ovch,
  input  logic             iready,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [AW-1:0]    wp [2];
  logic [AW-1:0]    rp [2];
  logic [AW:0]      cnt [2];
  logic [WIDTH-1:0] front [2];
  logic [1:0]       empty, full, head_ok, wr, deq;
  logic [1:0]       state;
  logic             last, pend, pend_vc, sel, acc;
  logic [1:0]       ftype;

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      empty[v]   = (cnt[v] == '0);
      full[v]    = (cnt[v] == FULL_CNT);
      front[v]   = mem[v][rp[v]];
      head_ok[v] = !empty[v] && front[v][WIDTH-1];
    end
  end

  assign acc   = ovalid & iready;
  assign deq   = {acc & sel, acc & ~sel};
  // A full FIFO still accepts a write when it is being drained in the same cycle.
  assign wr[0] = ivalid & ~ivch & (~full[0] | deq[0]);
  assign wr[1] = ivalid &  ivch & (~full[1] | deq[1]);

  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (wr[v]) mem[v][wp[v]] <= idata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < 2; v++) begin
        wp[v]  <= '0;
        rp[v]  <= '0;
        cnt[v] <= '0;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr[v])  wp[v] <= wp[v] + PTR_ONE;
        if (deq[v]) rp[v] <= rp[v] + PTR_ONE;
        if (wr[v] && !deq[v])      cnt[v] <= cnt[v] + CNT_ONE;
        else if (!wr[v] && deq[v]) cnt[v] <= cnt[v] - CNT_ONE;
      end
    end
  end

  // pend keeps an unaccepted IDLE grant stable even if the other VC becomes eligible.
  always_comb begin
    sel    = 1'b0;
    ovalid = 1'b0;
    case (state)
      LOCK0: begin
        sel    = 1'b0;
        ovalid = !empty[0];
      end
      LOCK1: begin
        sel    = 1'b1;
        ovalid = !empty[1];
      end
      default: begin
        if (pend) begin
          sel    = pend_vc;
          ovalid = 1'b1;
        end else if (&head_ok) begin
          sel    = ~last;
          ovalid = 1'b1;
        end else if (head_ok[0]) begin
          sel    = 1'b0;
          ovalid = 1'b1;
        end else if (head_ok[1]) begin
          sel    = 1'b1;
          ovalid = 1'b1;
        end
      end
    endcase
  end

  assign odata = sel ? front[1] : front[0];
  assign ovch  = sel;
  assign ftype = odata[WIDTH-1 -: 2];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      last    <= 1'b1;
      pend    <= 1'b0;
      pend_vc <= 1'b0;
      ocredit <= 2'b00;
    end else begin
      ocredit <= deq;
      pend    <= 1'b0;
      case (state)
        IDLE: begin
          pend    <= ovalid & ~iready;
          pend_vc <= sel;
          if (acc) begin
            last <= sel;
            if (ftype == 2'b10) state <= sel ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          if (acc && ftype[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_DEMUX_OVF_CHK_EN
  logic ovf;
  assign ovf = ivalid & (ivch ? (full[1] & ~deq[1]) : (full[0] & ~deq[0]));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) err <= 1'b0;
    else if (ovf) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
